nmr_pulse_sequencer: RTL and testbench
======================================

# nmr_pulse_sequencer

Programmable RF pulse-train scheduler for the NMR transmit path. It sequences the square-wave DAC source by driving its tone-select input (`tone`, wired to the generator's `genclk`) and its stream-valid gate (`gate`, wired to `enable`). One `start` plays N equal pulses separated by gaps, waits an acquisition delay, then fires a one-cycle acquisition trigger for the ADC capture path. All timing is in `aclk` cycles, and configuration is latched at start.

## Interface
- `CNT_WIDTH`, 32: width of all duration/period configuration inputs and internal counters
- `NUM_WIDTH`, 16: width of pulse-count configuration and `pulse_index`

- `aclk`  in  1  system clock; all logic on rising edge
- `aresetn`  in  1  synchronous active-low reset
- `start`  in  1  begin sequence; sampled only in IDLE
- `abort`  in  1  synchronous abort; returns to IDLE
- `cfg_half_period`  in  CNT_WIDTH  tone half-period in cycles (0 treated as 1)
- `cfg_pulse_len`  in  CNT_WIDTH  gate-high cycles per pulse (0 treated as 1)
- `cfg_gap_len`  in  CNT_WIDTH  gate-low cycles between pulses (0 = no gap)
- `cfg_num_pulses`  in  NUM_WIDTH  pulses per sequence (0 = start ignored)
- `cfg_acq_delay`  in  CNT_WIDTH  cycles from end of last pulse to `acq_trig`
- `tone`  out  1  square-wave select to generator `genclk`
- `gate`  out  1  generator enable / DAC stream valid
- `busy`  out  1  high in any state other than IDLE
- `pulse_index`  out  NUM_WIDTH  zero-based index of current/last pulse
- `acq_trig`  out  1  one-cycle acquisition trigger
- `done`  out  1  one-cycle completion strobe, coincident with `acq_trig`

## Operation
- States: IDLE, PULSE, GAP, ACQ_WAIT.
- IDLE: when `start`=1 and `cfg_num_pulses`≠0, latch all `cfg_*` (with zero-to-one substitutions), clear `pulse_index`, and go to PULSE. `start` is ignored in every other state.
- PULSE: `gate`=1 for exactly the latched pulse_len cycles.
  - The tone counter resets at each pulse entry and `tone`=0 on the first pulse cycle.
  - `tone` toggles after every half_period cycles within the pulse.
  - Exit when not last pulse: GAP if gap_len≠0, else directly into the next PULSE (gate stays high, tone phase resets to 0). `pulse_index` increments on entry to the next pulse.
  - Exit after last pulse: ACQ_WAIT.
- GAP: `gate`=0, `tone`=0 for gap_len cycles, then PULSE.
- ACQ_WAIT: `gate`=0, `tone`=0 for acq_delay cycles. Then `acq_trig`=1 and `done`=1 for one cycle, and the state returns to IDLE. With acq_delay=0, the strobe occurs on the cycle immediately after the last pulse cycle.
- `abort`: has priority over all transitions. Next cycle: state IDLE, `gate`=0, `tone`=0, `busy`=0, no `acq_trig`/`done`, and `pulse_index` holds.
- Config inputs changing mid-sequence have no effect. Counters are CNT_WIDTH unsigned and never wrap within a legal configuration.

## Timing
- All outputs are registered.
- Reset (`aresetn`=0 at a clock edge): state IDLE, and `tone`, `gate`, `busy`, `acq_trig`, `done`, `pulse_index` all 0. Reset mid-sequence behaves identically to reset from IDLE.
- `start` sampled high at edge N: `gate`=1 and `busy`=1 from cycle N+1.
- Pulse k spans cycles S_k to S_k+P−1 (P = pulse_len). S_{k+1} = S_k+P+G (G = gap_len).
- `tone` within a pulse is high on cycles where floor(offset/H) is odd (H = half_period, offset from pulse start).
- `acq_trig`/`done` fire at cycle S_last+P+D (D = acq_delay). `busy` is low from the following cycle.
- `start` coincident with the `done` cycle is ignored. It is accepted on the next cycle (IDLE).
- `abort` coincident with `start` in IDLE: stays IDLE.

## Test plan
- Reset and idle: `aresetn`=0 for 3 cycles, then 1 → all outputs 0. `start` with `cfg_num_pulses`=0 → `busy` stays 0.
- Single pulse: P=10, H=2, N=1, D=5, start at cycle 0 → `gate` high cycles 1–10. `tone` pattern 0,0,1,1,0,0,1,1,0,0. `acq_trig`=`done`=1 at cycle 16 only. `busy` 0 at 17.
- Train with gaps: P=4, G=6, N=3, H=1, D=0 → gate high 1–4, 11–14, 21–24. `pulse_index` 0,1,2. Strobe at cycle 25.
- Zero gap / zero substitutions: P=0, G=0, N=2, H=0 → gate high cycles 1–2. `tone` 0 on both cycles due to phase reset. Strobe at 3.
- Abort: P=100, N=2, abort at cycle 50 → `gate`/`busy`/`tone` 0 at 51. No `acq_trig`. A new `start` at 52 → gate high at 53.
- Start while busy and config change: pulse start at 5 during a running sequence is ignored. Changing `cfg_pulse_len` mid-sequence leaves pulse widths unchanged.

Source files
------------

// File: rtl/nmr_pulse_sequencer.sv
// nmr_pulse_sequencer
//   Schedules the RF pulse train for the NMR transmit path. One start plays
//   N equal pulses separated by optional gaps, waits an acquisition delay,
//   then strobes acq_trig/done for one cycle. Configuration is captured when
//   the sequence is accepted, so later changes to the cfg_* inputs do not
//   affect a running sequence.
//
// Ports
//   aclk, aresetn      clock; synchronous active-low reset
//   start, abort       start a sequence (IDLE only); abort to IDLE (top priority)
//   cfg_half_period    tone half-period in cycles (0 behaves as 1)
//   cfg_pulse_len      gate-high cycles per pulse (0 behaves as 1)
//   cfg_gap_len        gate-low cycles between pulses (0 = back-to-back)
//   cfg_num_pulses     pulses per sequence (0 = start ignored)
//   cfg_acq_delay      cycles from end of last pulse to the acquisition strobe
//   tone, gate         square-wave select and enable for the DAC source
//   busy               high whenever not IDLE
//   pulse_index        zero-based index of the current/last pulse
//   acq_trig, done     coincident one-cycle strobes at the end of a sequence
module nmr_pulse_sequencer #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_half_period,
  input  logic [CNT_WIDTH-1:0] cfg_pulse_len,
  input  logic [CNT_WIDTH-1:0] cfg_gap_len,
  input  logic [NUM_WIDTH-1:0] cfg_num_pulses,
  input  logic [CNT_WIDTH-1:0] cfg_acq_delay,
  output logic                 tone,
  output logic                 gate,
  output logic                 busy,
  output logic [NUM_WIDTH-1:0] pulse_index,
  output logic                 acq_trig,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_ACQ_WAIT
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] min_one(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

  state_t               state_q, state_d;
  logic                 tone_q, tone_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic                 trig_q, trig_d;
  logic                 done_q, done_d;
  logic [NUM_WIDTH-1:0] idx_q, idx_d;

  // rem counts the cycles still to come in the current state after this one;
  // tcnt is the position within the current tone half-period.
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [CNT_WIDTH-1:0] hp_q, hp_d;
  logic [CNT_WIDTH-1:0] pl_q, pl_d;
  logic [CNT_WIDTH-1:0] gl_q, gl_d;
  logic [NUM_WIDTH-1:0] np_q, np_d;
  logic [CNT_WIDTH-1:0] ad_q, ad_d;

  logic last_pulse;
  logic next_pulse;

  assign last_pulse = (idx_q == np_q - NUM_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tcnt_d     = tcnt_q;
    tone_d     = 1'b0;
    gate_d     = 1'b0;
    trig_d     = 1'b0;
    done_d     = 1'b0;
    idx_d      = idx_q;
    hp_d       = hp_q;
    pl_d       = pl_q;
    gl_d       = gl_q;
    np_d       = np_q;
    ad_d       = ad_q;
    next_pulse = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (cfg_num_pulses != '0)) begin
            hp_d    = min_one(cfg_half_period);
            pl_d    = min_one(cfg_pulse_len);
            gl_d    = cfg_gap_len;
            np_d    = cfg_num_pulses;
            ad_d    = cfg_acq_delay;
            idx_d   = '0;
            state_d = ST_PULSE;
            rem_d   = min_one(cfg_pulse_len) - CNT_WIDTH'(1);
            tcnt_d  = '0;
            gate_d  = 1'b1;
          end
        end
        ST_PULSE: begin
          if (rem_q != '0) begin
            rem_d  = rem_q - CNT_WIDTH'(1);
            gate_d = 1'b1;
            if (tcnt_q == hp_q - CNT_WIDTH'(1)) begin
              tcnt_d = '0;
              tone_d = ~tone_q;
            end else begin
              tcnt_d = tcnt_q + CNT_WIDTH'(1);
              tone_d = tone_q;
            end
          end else if (last_pulse) begin
            // Zero delay puts the strobe on the very next cycle.
            state_d = ST_ACQ_WAIT;
            rem_d   = ad_q;
            trig_d  = (ad_q == '0);
            done_d  = (ad_q == '0);
          end else if (gl_q != '0) begin
            state_d = ST_GAP;
            rem_d   = gl_q - CNT_WIDTH'(1);
          end else begin
            next_pulse = 1'b1;
          end
        end
        ST_GAP: begin
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_WIDTH'(1);
          end else begin
            next_pulse = 1'b1;
          end
        end
        ST_ACQ_WAIT: begin
          // The strobe cycle itself is the final ACQ_WAIT cycle (rem == 0).
          if (rem_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rem_d  = rem_q - CNT_WIDTH'(1);
            trig_d = (rem_q == CNT_WIDTH'(1));
            done_d = (rem_q == CNT_WIDTH'(1));
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Every pulse after the first starts with the tone phase reset.
      if (next_pulse) begin
        state_d = ST_PULSE;
        idx_d   = idx_q + NUM_WIDTH'(1);
        rem_d   = pl_q - CNT_WIDTH'(1);
        tcnt_d  = '0;
        tone_d  = 1'b0;
        gate_d  = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      tone_q  <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  // Counters and captured configuration are only read after being loaded on
  // sequence acceptance, so they carry no reset.
  always_ff @(posedge aclk) begin
    rem_q  <= rem_d;
    tcnt_q <= tcnt_d;
    hp_q   <= hp_d;
    pl_q   <= pl_d;
    gl_q   <= gl_d;
    np_q   <= np_d;
    ad_q   <= ad_d;
  end

  assign tone        = tone_q;
  assign gate        = gate_q;
  assign busy        = busy_q;
  assign pulse_index = idx_q;
  assign acq_trig    = trig_q;
  assign done        = done_q;

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// Bench for nmr_pulse_sequencer: directed scenarios, a closed-form schedule
// model checked every cycle, and hand-computed literal expectations.
module tb_nmr_pulse_sequencer;
  localparam int CW = 32;
  localparam int NW = 16;
  localparam int TR = 4096;

  logic          aclk = 1'b0;
  logic          aresetn, start, abort;
  logic [CW-1:0] cfg_half_period, cfg_pulse_len, cfg_gap_len, cfg_acq_delay;
  logic [NW-1:0] cfg_num_pulses;
  logic          tone, gate, busy, acq_trig, done;
  logic [NW-1:0] pulse_index;

  always #5 aclk = ~aclk;

  nmr_pulse_sequencer #(.CNT_WIDTH(CW), .NUM_WIDTH(NW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_half_period(cfg_half_period), .cfg_pulse_len(cfg_pulse_len),
    .cfg_gap_len(cfg_gap_len), .cfg_num_pulses(cfg_num_pulses),
    .cfg_acq_delay(cfg_acq_delay), .tone(tone), .gate(gate), .busy(busy),
    .pulse_index(pulse_index), .acq_trig(acq_trig), .done(done)
  );

  int checks = 0;
  int passes = 0;
  int ecnt   = 0;

  task automatic chk(input string name, input longint act_v, input longint exp_v);
    checks++;
    if (act_v == exp_v) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
  endtask

  // Schedule model: once a sequence is accepted at edge s0, the outputs after
  // edge e follow directly from off = e - s0 and the captured parameters.
  bit     act = 0;
  longint s0, mP, mG, mN, mH, mD, mL;
  bit     e_gate, e_tone, e_busy, e_trig;
  longint e_idx = 0, hold_idx = 0;

  always @(posedge aclk) begin : model
    longint off, r;
    ecnt++;
    if (!aresetn) begin
      act = 0; hold_idx = 0;
    end else if (abort) begin
      if (act) hold_idx = e_idx;
      act = 0;
    end else if (act) begin
      if (longint'(ecnt) - s0 > mL + mD) begin
        act = 0; hold_idx = mN - 1;
      end
    end else if (start && cfg_num_pulses != 0) begin
      mP = (cfg_pulse_len == 0) ? 1 : longint'(cfg_pulse_len);
      mH = (cfg_half_period == 0) ? 1 : longint'(cfg_half_period);
      mG = longint'(cfg_gap_len);
      mN = longint'(cfg_num_pulses);
      mD = longint'(cfg_acq_delay);
      mL = (mN - 1) * (mP + mG) + mP;
      s0 = ecnt;
      act = 1;
    end
    e_gate = 0; e_tone = 0; e_busy = 0; e_trig = 0; e_idx = hold_idx;
    if (act) begin
      off = longint'(ecnt) - s0;
      e_busy = 1;
      if (off < mL) begin
        e_idx = off / (mP + mG);
        r = off % (mP + mG);
        if (r < mP) begin
          e_gate = 1;
          e_tone = ((r / mH) % 2) == 1;
        end
      end else begin
        e_idx = mN - 1;
        if (off == mL + mD) e_trig = 1;
      end
    end
  end

  int tr_gate[TR], tr_tone[TR], tr_busy[TR], tr_trig[TR], tr_done[TR], tr_idx[TR];

  always @(negedge aclk) begin
    if (ecnt > 0 && ecnt < TR) begin
      tr_gate[ecnt] = gate;  tr_tone[ecnt] = tone;  tr_busy[ecnt] = busy;
      tr_trig[ecnt] = acq_trig; tr_done[ecnt] = done; tr_idx[ecnt] = pulse_index;
      chk($sformatf("outputs@%0d {idx,busy,gate,tone,trig,done}", ecnt),
          {pulse_index, busy, gate, tone, acq_trig, done},
          {NW'(e_idx), e_busy, e_gate, e_tone, e_trig, e_trig});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Raises start for one edge; s is the edge index at which it is sampled.
  task automatic go(output int s);
    start = 1'b1;
    s = ecnt + 1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int g, input int n, input int h, input int d);
    cfg_pulse_len = p; cfg_gap_len = g; cfg_num_pulses = NW'(n);
    cfg_half_period = h; cfg_acq_delay = d;
  endtask

  int s;
  int tone_pat[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
  int tr_offs[10]  = '{0, 3, 4, 9, 10, 13, 14, 20, 23, 24};
  int tr_gexp[10]  = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0};

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset and idle
    tick(3);
    aresetn = 1'b1;
    tick(1);
    chk("reset_outputs", {tr_idx[ecnt], tr_busy[ecnt], tr_gate[ecnt], tr_tone[ecnt],
                          tr_trig[ecnt], tr_done[ecnt]}, 0);
    set_cfg(5, 0, 0, 1, 0);
    go(s);
    tick(3);
    chk("zero_pulses_busy0", tr_busy[s], 0);
    chk("zero_pulses_busy1", tr_busy[s+1], 0);

    // Single pulse: P=10 H=2 N=1 D=5
    set_cfg(10, 0, 1, 2, 5);
    go(s);
    tick(20);
    for (int o = 0; o < 10; o++) begin
      chk($sformatf("single_gate_off%0d", o), tr_gate[s+o], 1);
      chk($sformatf("single_tone_off%0d", o), tr_tone[s+o], tone_pat[o]);
    end
    chk("single_gate_end", tr_gate[s+10], 0);
    chk("single_trig_early", tr_trig[s+14], 0);
    chk("single_trig", tr_trig[s+15], 1);
    chk("single_done", tr_done[s+15], 1);
    chk("single_trig_late", tr_trig[s+16], 0);
    chk("single_busy_strobe", tr_busy[s+15], 1);
    chk("single_busy_after", tr_busy[s+16], 0);

    // Train with gaps: P=4 G=6 N=3 H=1 D=0
    set_cfg(4, 6, 3, 1, 0);
    go(s);
    tick(30);
    for (int i = 0; i < 10; i++)
      chk($sformatf("train_gate_off%0d", tr_offs[i]), tr_gate[s+tr_offs[i]], tr_gexp[i]);
    chk("train_idx0", tr_idx[s], 0);
    chk("train_idx1", tr_idx[s+10], 1);
    chk("train_idx2", tr_idx[s+20], 2);
    chk("train_trig_early", tr_trig[s+23], 0);
    chk("train_trig", tr_trig[s+24], 1);

    // Zero gap and zero-to-one substitutions: P=0 G=0 N=2 H=0 D=0
    set_cfg(0, 0, 2, 0, 0);
    go(s);
    tick(6);
    chk("zero_gate_off0", tr_gate[s], 1);
    chk("zero_gate_off1", tr_gate[s+1], 1);
    chk("zero_gate_off2", tr_gate[s+2], 0);
    chk("zero_tone_off0", tr_tone[s], 0);
    chk("zero_tone_off1", tr_tone[s+1], 0);
    chk("zero_idx_off1", tr_idx[s+1], 1);
    chk("zero_trig", tr_trig[s+2], 1);

    // Abort mid-pulse, restart, then start coincident with abort in IDLE
    set_cfg(100, 0, 2, 3, 0);
    go(s);
    tick(49);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("abort_gate_before", tr_gate[s+49], 1);
    chk("abort_gate", tr_gate[s+50], 0);
    chk("abort_busy", tr_busy[s+50], 0);
    chk("abort_tone", tr_tone[s+50], 0);
    chk("abort_idx_hold", tr_idx[s+50], 0);
    chk("abort_restart_gate", tr_gate[s+51], 1);
    abort = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    tick(3);
    chk("abort_with_start_busy", tr_busy[s+56], 0);

    // Start while busy and config change mid-sequence: P=8 G=4 N=3 H=2 D=3
    set_cfg(8, 4, 3, 2, 3);
    go(s);
    tick(4);
    start = 1'b1;
    cfg_pulse_len = 2; cfg_num_pulses = 1;
    tick(1);
    start = 1'b0;
    tick(s + 35 - ecnt);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(10);
    chk("cfgchg_gate_p1_start", tr_gate[s+12], 1);
    chk("cfgchg_gate_p1_end", tr_gate[s+19], 1);
    chk("cfgchg_gate_p1_after", tr_gate[s+20], 0);
    chk("cfgchg_trig", tr_trig[s+35], 1);
    chk("done_cycle_start_ignored", tr_busy[s+36], 0);
    chk("start_after_done_busy", tr_busy[s+37], 1);
    chk("new_cfg_gate0", tr_gate[s+38], 1);
    chk("new_cfg_gate_end", tr_gate[s+39], 0);
    chk("new_cfg_trig", tr_trig[s+42], 1);

    // Reset mid-sequence
    set_cfg(8, 4, 3, 2, 3);
    go(s);
    tick(3);
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    tick(3);
    chk("midreset_busy_before", tr_busy[s+3], 1);
    chk("midreset_outputs", {tr_idx[s+4], tr_busy[s+4], tr_gate[s+4], tr_tone[s+4],
                             tr_trig[s+4], tr_done[s+4]}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
